// File: rtl/traffic_ctrl_n.sv
// traffic_ctrl_n
// Two-direction traffic-light controller with an NDIG-digit BCD countdown and
// a multiplexed 7-segment display driver. Single clock; sec_tick and
// scan_tick are one-cycle enables from the board tick generator.
//
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   sec_tick             decrements the countdown / advances the phase
//   scan_tick            advances the displayed digit
//   force_ew, force_ns   hold EW green (10), NS green (01), or all red (11)
//   lamp_test            all lamps and segments on; logic keeps running
//   ew_rgy, ns_rgy       lamps {red, yellow, green}, active-high
//   seg                  segments {a..g}, active-high
//   dig_n                one-hot active-low digit select, bit 0 = LSD
//   phase                current FSM state code
module traffic_ctrl_n #(
  parameter int NDIG  = 2,
  parameter int GRN_S = 40,
  parameter int YEL_S = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sec_tick,
  input  logic            scan_tick,
  input  logic            force_ew,
  input  logic            force_ns,
  input  logic            lamp_test,
  output logic [2:0]      ew_rgy,
  output logic [2:0]      ns_rgy,
  output logic [6:0]      seg,
  output logic [NDIG-1:0] dig_n,
  output logic [2:0]      phase
);

  localparam int CW   = 4 * NDIG;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  function automatic logic [CW-1:0] to_bcd(input int v);
    logic [CW-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [CW-1:0] GRN_BCD = to_bcd(GRN_S);
  localparam logic [CW-1:0] YEL_BCD = to_bcd(YEL_S);
  localparam logic [CW-1:0] ONE_BCD = CW'(1);

  typedef enum logic [2:0] {
    EW_G    = 3'd0,
    EW_Y    = 3'd1,
    NS_G    = 3'd2,
    NS_Y    = 3'd3,
    TRANS_Y = 3'd4,
    HOLD    = 3'd5
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next, cnt_dec;
  logic [1:0]      force_in, force_q, force_next;
  // Which direction shows yellow while in TRANS_Y: {ew, ns}. 00 = both red.
  logic [1:0]      tmode, tmode_next;
  logic [IDXW-1:0] idx;
  logic [2:0]      ew_next, ns_next, ew_reg, ns_reg;
  logic [6:0]      seg_next, seg_reg;
  logic [NDIG-1:0] dig_next, dig_reg;
  logic [3:0]      digs [NDIG];
  logic [3:0]      cur_digit;

  assign force_in = {force_ew, force_ns};

  // BCD decrement: each digit borrows only when all lower digits are zero.
  logic [NDIG-1:0] borrow;
  assign borrow[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_dig
      logic [3:0] d;
      assign d       = cnt[4*gi +: 4];
      assign digs[gi] = d;
      assign cnt_dec[4*gi +: 4] = borrow[gi] ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;
      if (gi < NDIG - 1) begin : g_borrow
        assign borrow[gi+1] = borrow[gi] & (d == 4'd0);
      end
    end
  endgenerate

  // Next-state: a force change beats a coincident sec_tick.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    force_next = force_q;
    tmode_next = tmode;
    if (force_in != force_q) begin
      force_next = force_in;
      state_next = TRANS_Y;
      cnt_next   = YEL_BCD;
      case (state)
        EW_G, EW_Y: tmode_next = 2'b10;
        NS_G, NS_Y: tmode_next = 2'b01;
        // Leaving HOLD: the held-green direction goes yellow; 11 stays all red.
        HOLD:       tmode_next = (force_q == 2'b11) ? 2'b00 : force_q;
        default:    tmode_next = tmode;  // restart in TRANS_Y keeps the lamps
      endcase
    end else if (sec_tick && state != HOLD) begin
      if (cnt == ONE_BCD) begin
        case (state)
          EW_G: begin state_next = EW_Y; cnt_next = YEL_BCD; end
          EW_Y: begin state_next = NS_G; cnt_next = GRN_BCD; end
          NS_G: begin state_next = NS_Y; cnt_next = YEL_BCD; end
          NS_Y: begin state_next = EW_G; cnt_next = GRN_BCD; end
          TRANS_Y: begin
            if (force_q == 2'b00) begin
              state_next = EW_G;
              cnt_next   = GRN_BCD;
            end else begin
              state_next = HOLD;
            end
          end
          default: ;
        endcase
      end else begin
        cnt_next = cnt_dec;
      end
    end
  end

  // Lamps are derived from the next state so they register on the same edge.
  always_comb begin
    ew_next = 3'b100;
    ns_next = 3'b100;
    case (state_next)
      EW_G: ew_next = 3'b001;
      EW_Y: ew_next = 3'b010;
      NS_G: ns_next = 3'b001;
      NS_Y: ns_next = 3'b010;
      TRANS_Y: begin
        if (tmode_next[1]) ew_next = 3'b010;
        if (tmode_next[0]) ns_next = 3'b010;
      end
      HOLD: begin
        if (force_next == 2'b10) ew_next = 3'b001;
        else if (force_next == 2'b01) ns_next = 3'b001;
      end
      default: ;
    endcase
    if (lamp_test) begin
      ew_next = 3'b111;
      ns_next = 3'b111;
    end
  end

  assign cur_digit = digs[idx];

  always_comb begin
    seg_next = 7'h00;
    case (cur_digit)
      4'd0: seg_next = 7'h7E;
      4'd1: seg_next = 7'h30;
      4'd2: seg_next = 7'h6D;
      4'd3: seg_next = 7'h79;
      4'd4: seg_next = 7'h33;
      4'd5: seg_next = 7'h5B;
      4'd6: seg_next = 7'h5F;
      4'd7: seg_next = 7'h70;
      4'd8: seg_next = 7'h7F;
      4'd9: seg_next = 7'h7B;
      default: seg_next = 7'h00;
    endcase
    if (state == HOLD) seg_next = 7'h01;  // dash
    if (lamp_test)     seg_next = 7'h7F;
    dig_next = ~(NDIG'(1) << idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EW_G;
      cnt     <= GRN_BCD;
      force_q <= 2'b00;
      tmode   <= 2'b00;
      idx     <= '0;
      ew_reg  <= 3'b001;
      ns_reg  <= 3'b100;
      seg_reg <= 7'h00;
      dig_reg <= '1;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      force_q <= force_next;
      tmode   <= tmode_next;
      ew_reg  <= ew_next;
      ns_reg  <= ns_next;
      seg_reg <= seg_next;
      dig_reg <= dig_next;
      if (scan_tick) begin
        idx <= (idx == IDXW'(NDIG - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  assign ew_rgy = ew_reg;
  assign ns_rgy = ns_reg;
  assign seg    = seg_reg;
  assign dig_n  = dig_reg;
  assign phase  = state;

endmodule

// File: doc/traffic_ctrl_n.md
# traffic_ctrl_n

Parametrised two-direction traffic-light controller with an NDIG-digit BCD countdown and a multiplexed 7-segment display driver. It is the next generation of the 2-digit junction controller. Changes from that controller:
- A single clock with tick enables replaces the separate count and scan clocks.
- Phase durations come from parameters.
- Force changes are detected on every clock, not only on count ticks.
- Lamp test is a separate override input.

The block sits between the board tick generator (1 Hz `sec_tick`, ~1 kHz `scan_tick`) and the lamp/LED pins.

## Interface
- `NDIG`, 2, number of BCD display digits (1..4).
- `GRN_S`, 40, green duration in seconds. Must satisfy 1 ≤ value < 10^NDIG.
- `YEL_S`, 3, yellow duration in seconds. Same range rule as `GRN_S`.
- `clk`  in  1  system clock; all state changes on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sec_tick`  in  1  one-cycle pulse; decrements the countdown.
- `scan_tick`  in  1  one-cycle pulse; advances the display digit.
- `force_ew`  in  1  hold east-west green, north-south red.
- `force_ns`  in  1  hold north-south green, east-west red.
- `lamp_test`  in  1  output override: all lamps and segments on.
- `ew_rgy`  out  3  east-west lamps {red, yellow, green}, active-high.
- `ns_rgy`  out  3  north-south lamps {red, yellow, green}, active-high.
- `seg`  out  7  segments {a..g}, active-high.
- `dig_n`  out  NDIG  digit select, one-hot, active-low; bit 0 is the least-significant digit.
- `phase`  out  3  current FSM state code.

## Operation

**States and codes**
- EW_G=0, EW_Y=1, NS_G=2, NS_Y=3, TRANS_Y=4, HOLD=5.

**Lamps per state**
- EW_G: EW green, NS red.
- EW_Y: EW yellow, NS red.
- NS_G: NS green, EW red.
- NS_Y: NS yellow, EW red.
- TRANS_Y:
  - The direction that was green or yellow on entry shows yellow; the other shows red.
  - If entered from HOLD with force 11, both show red.
- HOLD: force=10 gives EW green / NS red; 01 gives NS green / EW red; 11 gives both red.

**Countdown**
- `cnt` is NDIG BCD digits; each decrement uses a borrow chain.
- Each phase loads its duration, and the display counts from that value down to 1. It never shows 0.
- On `sec_tick` with `cnt`==1, the FSM moves to the next state and loads that state's duration. Otherwise `cnt` decrements by 1.

**Normal cycle (force=00)**
- EW_G(GRN_S) → EW_Y(YEL_S) → NS_G(GRN_S) → NS_Y(YEL_S) → EW_G.

**Force handling**
- A registered copy `force_q` of {force_ew, force_ns} is compared against the inputs every clock.
- On any difference, `force_q` updates and the FSM enters TRANS_Y with `cnt`=YEL_S. This applies from any state, including TRANS_Y itself, which restarts the yellow period with the lamps unchanged.
- When TRANS_Y expires:
  - `force_q`==00: go to EW_G and load GRN_S.
  - Otherwise: go to HOLD.
- In HOLD, `cnt` is frozen and every digit shows a dash (g only).
- A force change and a `sec_tick` in the same cycle: the force change wins and the tick is discarded.

**Display**
- On `scan_tick`, digit index `idx` advances 0→NDIG-1 and wraps.
- Outputs are registered one cycle after `idx`/`cnt`:
  - `dig_n` = ~(1<<idx).
  - `seg` = decode(cnt digit idx): 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B.
- Leading zeros are displayed.

**Lamp test**
- While `lamp_test`=1: `ew_rgy`=`ns_rgy`=111 and `seg`=7F. Scanning continues.
- The FSM and countdown keep running underneath, so releasing lamp test shows the live state.

## Timing
- Reset (async assert, synchronous-to-clk release), state on reset:
  - FSM: EW_G, `cnt`=GRN_S, `force_q`=00, `idx`=0.
  - Outputs: `ew_rgy`=001, `ns_rgy`=100, `phase`=0, `seg`=00, `dig_n`=all ones.
- Reset asserted mid-phase takes effect immediately, with no yellow.
- Lamp and `phase` outputs are registered and change in the cycle after the triggering tick or force edge.
- `seg`/`dig_n` lag `idx`/`cnt` by one cycle.
- Ticks are assumed single-cycle. A tick held high for k cycles counts as k ticks.
- The first cycle after reset release samples force. If force≠00 at that point, TRANS_Y is entered on that cycle.

## Test plan
- Reset with defaults, force=00, 90 `sec_tick`s:
  - Display counts 40..1, then 03..01, then 40..1, then 03..01.
  - `phase` goes 0,1,2,3,0.
  - The lamps match each state at every transition.
- NDIG=3, GRN_S=125: `cnt` borrow 100→099 is correct; `dig_n` cycles 110,101,011.
- Pulse `force_ns`=1 at EW_G with `cnt`=25:
  - Next cycle: TRANS_Y, EW yellow, display 03.
  - After 3 ticks: HOLD, NS green, EW red, dashes displayed.
  - Release force: TRANS_Y with NS yellow, then EW_G at 40.
- Toggle force 10→11 during TRANS_Y at `cnt`=1, on the same cycle as a `sec_tick`: TRANS_Y restarts at 03 and the tick is ignored. Final HOLD has both directions red.
- Assert `lamp_test` during NS_G at 17 for 5 ticks, then release: all lamps 111 and `seg`=7F while asserted; NS_G at 12 after release.
- Assert `rst_n`=0 mid EW_Y asynchronously: outputs reach their reset values before the next clock edge.
